// File: rtl/strela_stream_pkg.sv
// Shared types and constants for the CGRA input-node stream address generator.
package strela_stream_pkg;

    // Memory is word addressed in bytes; one beat moves WORD_BYTES bytes.
    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    // Controller states. busy is every state except IDLE and DONE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } agu_state_e;

endpackage

// File: rtl/input_stream_agu_if.sv
// Bus bundle of the input stream AGU: OBI-style read port plus output stream.
//
// Handshake rules:
//   memory request : a beat is accepted on a clock edge where mem_req_o and
//                    mem_gnt_i are both high; mem_req_o and mem_addr_o stay
//                    stable until that edge. Responses come back in order,
//                    one word per cycle with mem_rvalid_i high.
//   output stream  : a word transfers on a clock edge where valid_o and
//                    ready_i are both high; data_o is stable while valid_o is
//                    high and not yet accepted. valid_o never depends on ready_i.
interface input_stream_agu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;

    // AGU side drives requests and the stream.
    modport master (
        output mem_req_o, mem_addr_o, data_o, valid_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i
    );

    // Memory / fabric side.
    modport slave (
        input  mem_req_o, mem_addr_o, data_o, valid_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i
    );
endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding read data between memory and the fabric.
// Flush wins over push/pop in the same cycle.
module stream_fifo #(
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_stream_agu.sv
// Input-node address generator: walks base/stride over size bytes, issues
// word reads with a credit limit equal to the FIFO depth, and streams the
// buffered read data into the fabric. done_o is sticky until the next start
// or a clear.
module input_stream_agu
    import strela_stream_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SIZE_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   cfg_addr_i,
    input  logic [SIZE_W-1:0]   cfg_size_i,
    input  logic [SIZE_W-1:0]   cfg_stride_i,
    input  logic                execute_i,
    input  logic                clear_i,
    input_stream_agu_if.master  bus,
    output logic                done_o,
    output logic                busy_o,
    output agu_state_e          state_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    agu_state_e        state;
    agu_state_e        state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [SIZE_W-1:0] words_left;
    logic [SIZE_W-1:0] stride;
    logic [SIZE_W-1:0] size_words;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_use;
    logic              fifo_empty;
    logic              fifo_full;
    logic              start;
    logic              req;
    logic              gnt;
    logic              rsp;
    logic              push;
    logic              pop;

    assign size_words = cfg_size_i >> WORD_SHIFT;
    assign start      = execute_i && !clear_i && (state == IDLE || state == DONE);

    // Credit check: buffered words plus reads in flight must leave room in
    // the FIFO, so every response always has a slot.
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};
    assign req    = (state == ISSUE) && (in_use < (CNT_W + 1)'(FIFO_DEPTH));
    assign gnt    = req && bus.mem_gnt_i;
    assign rsp    = bus.mem_rvalid_i && (outstanding != '0);

    // Responses are buffered only while a transfer is live; in ABORT and on
    // the clear cycle they are counted off and dropped.
    assign push = rsp && !clear_i && !fifo_full && (state == ISSUE || state == DRAIN);
    assign pop  = !fifo_empty && bus.ready_i;

    assign bus.mem_req_o  = req;
    assign bus.mem_addr_o = cur_addr;
    assign bus.valid_o    = !fifo_empty;
    assign done_o         = (state == DONE);
    assign busy_o         = (state != IDLE) && (state != DONE);
    assign state_o        = state;

    // Reads in flight after this cycle: grant adds one, response removes one.
    always_comb begin
        outstanding_next = outstanding;
        case ({gnt, rsp})
            2'b10:   outstanding_next = outstanding + CNT_W'(1);
            2'b01:   outstanding_next = outstanding - CNT_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    // Next-state logic; clear overrides everything including a same-cycle execute.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (execute_i) begin
                    state_next = (size_words != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (gnt && words_left == SIZE_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0 && fifo_empty) begin
                    state_next = DONE;
                end
            end
            ABORT: begin
                if (outstanding_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear_i) begin
            state_next = (outstanding_next != '0) ? ABORT : IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address walker, word countdown and in-flight counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_addr    <= '0;
            words_left  <= '0;
            stride      <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (start) begin
                cur_addr   <= cfg_addr_i;
                words_left <= size_words;
                stride     <= cfg_stride_i;
            end else if (gnt) begin
                cur_addr   <= cur_addr + ADDR_W'(stride);
                words_left <= words_left - SIZE_W'(1);
            end
        end
    end

    stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (clear_i),
        .wdata (bus.mem_rdata_i),
        .rdata (bus.data_o),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_input_stream_agu.sv
// Directed bench for input_stream_agu: memory responder with 1-cycle read
// latency, stream sink log, and one task per scenario.
module tb_input_stream_agu;
    import strela_stream_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cfg_addr;
    logic [SIZE_W-1:0] cfg_size;
    logic [SIZE_W-1:0] cfg_stride;
    logic              execute;
    logic              clear;
    logic              done;
    logic              busy;
    agu_state_e        state;

    int errors = 0;
    int checks = 0;

    logic              resp_en;
    logic [ADDR_W-1:0] resp_q[$];
    logic [ADDR_W-1:0] req_log[$];
    logic [DATA_W-1:0] out_log[$];
    logic [ADDR_W-1:0] exp_q[$];

    input_stream_agu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    input_stream_agu #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SIZE_W     (SIZE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_addr_i   (cfg_addr),
        .cfg_size_i   (cfg_size),
        .cfg_stride_i (cfg_stride),
        .execute_i    (execute),
        .clear_i      (clear),
        .bus          (bus),
        .done_o       (done),
        .busy_o       (busy),
        .state_o      (state)
    );

    // clock
    always #5 clk = ~clk;

    // Memory contents: each word is its address with the top half scrambled.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Mid-cycle monitor: log granted requests, retire presented responses, log stream pops.
    always @(negedge clk) begin
        if (bus.mem_rvalid_i && resp_q.size() > 0) void'(resp_q.pop_front());
        if (bus.mem_req_o && bus.mem_gnt_i) begin
            resp_q.push_back(bus.mem_addr_o);
            req_log.push_back(bus.mem_addr_o);
        end
        if (bus.valid_o && bus.ready_i) out_log.push_back(bus.data_o);
    end

    // Responder: present the oldest granted read in the cycle after its grant.
    always @(posedge clk) begin
        #2;
        if (resp_en && resp_q.size() > 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = mem_word(resp_q[0]);
        end else begin
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ADDR_W-1:0] a, input logic [SIZE_W-1:0] s,
                         input logic [SIZE_W-1:0] st);
        cfg_addr   = a;
        cfg_size   = s;
        cfg_stride = st;
        execute    = 1'b1;
        tick();
        execute    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        ok = done;
    endtask

    task automatic clear_logs();
        req_log.delete();
        out_log.delete();
        exp_q.delete();
    endtask

    task automatic build_exp(input logic [ADDR_W-1:0] a, input int n, input logic [ADDR_W-1:0] st);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(a + st * i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.valid_o !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b done=%b busy=%b, required all 0",
                     bus.mem_req_o, bus.valid_o, done, busy);
        end
        checks++;
        if (state !== IDLE || bus.mem_addr_o !== '0 || bus.data_o !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%s addr=%h data=%h, required IDLE/0/0",
                     state.name(), bus.mem_addr_o, bus.data_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int bad = 0;
        clear_logs();
        bus.mem_gnt_i = 1'b1;
        bus.ready_i   = 1'b1;
        resp_en       = 1'b1;
        start(32'h8000_0000, 16'd80, 16'd4);
        wait_done(200, ok);
        build_exp(32'h8000_0000, 20, 32'd4);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: done_o=%b, required 1 within budget", done); end
        checks++;
        if (req_log.size() != 20) begin
            errors++; $display("FAIL basic_req_count: got %0d requests, required 20", req_log.size());
        end
        for (int i = 0; i < 20 && i < req_log.size() && i < out_log.size(); i++) begin
            if (req_log[i] !== exp_q[i] || out_log[i] !== mem_word(exp_q[i])) bad++;
        end
        checks++;
        if (out_log.size() != 20 || bad != 0) begin
            errors++; $display("FAIL basic_stream: words=%0d bad=%0d, required 20 words in order, 0 bad",
                               out_log.size(), bad);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: busy_o=%b, required 0", busy); end
        repeat (3) tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL basic_done_sticky: done_o=%b, required 1", done); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        clear_logs();
        bus.ready_i = 1'b0;
        start(32'h8000_0000, 16'd80, 16'd4);
        repeat (30) tick();
        checks++;
        if (req_log.size() != FIFO_DEPTH) begin
            errors++; $display("FAIL bp_req_count: got %0d requests while stalled, required 4", req_log.size());
        end
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_full: req=%b valid=%b, required req 0 valid 1",
                               bus.mem_req_o, bus.valid_o);
        end
        bus.ready_i = 1'b1;
        wait_done(200, ok);
        build_exp(32'h8000_0000, 20, 32'd4);
        for (int i = 0; i < 20 && i < out_log.size(); i++) begin
            if (out_log[i] !== mem_word(exp_q[i])) bad++;
        end
        checks++;
        if (!ok || out_log.size() != 20 || req_log.size() != 20 || bad != 0) begin
            errors++; $display("FAIL bp_release: done=%b words=%0d reqs=%0d bad=%0d, required 1/20/20/0",
                               ok, out_log.size(), req_log.size(), bad);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad = 0;
        logic [ADDR_W-1:0] wrap_tbl [4];
        wrap_tbl[0] = 32'hFFFF_FFF8;
        wrap_tbl[1] = 32'h0000_0000;
        wrap_tbl[2] = 32'h0000_0008;
        wrap_tbl[3] = 32'h0000_0010;
        clear_logs();
        start(32'hFFFF_FFF8, 16'd16, 16'd8);
        wait_done(100, ok);
        for (int i = 0; i < 4 && i < req_log.size() && i < out_log.size(); i++) begin
            if (req_log[i] !== wrap_tbl[i] || out_log[i] !== mem_word(wrap_tbl[i])) bad++;
        end
        checks++;
        if (!ok || req_log.size() != 4 || out_log.size() != 4 || bad != 0) begin
            errors++; $display("FAIL wrap_addresses: done=%b reqs=%0d words=%0d bad=%0d, required 1/4/4/0",
                               ok, req_log.size(), out_log.size(), bad);
        end
    endtask

    task automatic test_zero_and_unaligned();
        bit ok;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (done !== 1'b0 || state !== IDLE) begin
            errors++; $display("FAIL clear_from_done: done=%b state=%s, required 0/IDLE", done, state.name());
        end
        clear_logs();
        start(32'h6000, 16'd0, 16'd4);
        checks++;
        if (done !== 1'b1 || bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL zero_size_done: done=%b req=%b one cycle after execute, required 1/0",
                               done, bus.mem_req_o);
        end
        repeat (4) tick();
        checks++;
        if (req_log.size() != 0 || done !== 1'b1) begin
            errors++; $display("FAIL zero_size_traffic: reqs=%0d done=%b, required 0/1", req_log.size(), done);
        end
        start(32'h7000, 16'd7, 16'd4);
        wait_done(100, ok);
        checks++;
        if (!ok || req_log.size() != 1 || out_log.size() != 1) begin
            errors++; $display("FAIL size7_count: done=%b reqs=%0d words=%0d, required 1/1/1",
                               ok, req_log.size(), out_log.size());
        end else if (req_log[0] !== 32'h7000 || out_log[0] !== mem_word(32'h7000)) begin
            errors++; $display("FAIL size7_count: addr=%h data=%h, required 00007000/%h",
                               req_log[0], out_log[0], mem_word(32'h7000));
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n = 0;
        int bad = 0;
        clear_logs();
        bus.ready_i = 1'b0;
        resp_en     = 1'b0;
        start(32'h4000, 16'd80, 16'd4);
        repeat (6) tick();
        resp_en = 1'b1;
        tick();
        resp_en = 1'b0;
        checks++;
        if (req_log.size() != 4 || bus.valid_o !== 1'b1 || bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL abort_setup: reqs=%0d valid=%b req=%b, required 4/1/0",
                               req_log.size(), bus.valid_o, bus.mem_req_o);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.mem_req_o !== 1'b0 || state !== ABORT || done !== 1'b0) begin
            errors++; $display("FAIL abort_enter: valid=%b req=%b state=%s done=%b, required 0/0/ABORT/0",
                               bus.valid_o, bus.mem_req_o, state.name(), done);
        end
        bus.ready_i = 1'b1;
        resp_en     = 1'b1;
        while (state != IDLE && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (state !== IDLE || out_log.size() != 0 || done !== 1'b0 || req_log.size() != 4) begin
            errors++; $display("FAIL abort_discard: state=%s words=%0d done=%b reqs=%0d, required IDLE/0/0/4",
                               state.name(), out_log.size(), done, req_log.size());
        end
        clear_logs();
        start(32'h5000, 16'd16, 16'd4);
        wait_done(100, ok);
        build_exp(32'h5000, 4, 32'd4);
        for (int i = 0; i < 4 && i < req_log.size() && i < out_log.size(); i++) begin
            if (req_log[i] !== exp_q[i] || out_log[i] !== mem_word(exp_q[i])) bad++;
        end
        checks++;
        if (!ok || req_log.size() != 4 || out_log.size() != 4 || bad != 0) begin
            errors++; $display("FAIL abort_restart: done=%b reqs=%0d words=%0d bad=%0d, required 1/4/4/0",
                               ok, req_log.size(), out_log.size(), bad);
        end
    endtask

    task automatic test_retrigger();
        bit ok;
        int bad = 0;
        clear_logs();
        start(32'h2000, 16'd32, 16'd4);
        tick();
        cfg_addr = 32'h9000;
        cfg_size = 16'd400;
        execute  = 1'b1;
        tick();
        execute  = 1'b0;
        wait_done(100, ok);
        build_exp(32'h2000, 8, 32'd4);
        for (int i = 0; i < 8 && i < req_log.size() && i < out_log.size(); i++) begin
            if (req_log[i] !== exp_q[i] || out_log[i] !== mem_word(exp_q[i])) bad++;
        end
        checks++;
        if (!ok || req_log.size() != 8 || out_log.size() != 8 || bad != 0) begin
            errors++; $display("FAIL retrigger_ignored: done=%b reqs=%0d words=%0d bad=%0d, required 1/8/8/0",
                               ok, req_log.size(), out_log.size(), bad);
        end
        clear_logs();
        start(32'h3000, 16'd8, 16'd4);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL done_rearm: done=%b busy=%b after execute in DONE, required 0/1", done, busy);
        end
        wait_done(100, ok);
        checks++;
        if (!ok || req_log.size() != 2 || out_log.size() != 2) begin
            errors++; $display("FAIL second_transfer: done=%b reqs=%0d words=%0d, required 1/2/2",
                               ok, req_log.size(), out_log.size());
        end else if (req_log[1] !== 32'h3004 || out_log[1] !== mem_word(32'h3004)) begin
            errors++; $display("FAIL second_transfer: last addr=%h data=%h, required 00003004/%h",
                               req_log[1], out_log[1], mem_word(32'h3004));
        end
    endtask

    initial begin
        rst              = 1'b1;
        cfg_addr         = '0;
        cfg_size         = '0;
        cfg_stride       = '0;
        execute          = 1'b0;
        clear            = 1'b0;
        resp_en          = 1'b1;
        bus.mem_gnt_i    = 1'b0;
        bus.ready_i      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_unaligned();
        test_abort();
        test_retrigger();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
